// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned PHASE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler: 2-bit phase counter plus a 24-bit
// history of the bytes already received for the current word.
module byte_packer
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               accept,
  input  logic [BYTE_W-1:0]  byteIn,
  input  logic               clear,
  output logic [DATA_W-1:0]  wordC,
  output logic               wordCompleteC,
  output logic [PHASE_W-1:0] phase
);

  localparam int unsigned HIST_W = DATA_W - BYTE_W;

  logic [HIST_W-1:0] shiftQ;

  // Phase counter and byte history; history needs no clearing since a
  // full word always shifts in three fresh bytes first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= '0;
      shiftQ <= '0;
    end else if (clear) begin
      phase  <= '0;
    end else if (accept) begin
      phase  <= phase + PHASE_W'(1);
      shiftQ <= {shiftQ[HIST_W-BYTE_W-1:0], byteIn};
    end
  end

  // The word is complete on the edge that accepts the fourth byte.
  always_comb begin
    wordC         = {shiftQ, byteIn};
    wordCompleteC = accept && (phase == PHASE_W'(3));
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: passes fetch addresses through while running,
// and on request stalls the CPU and writes a byte stream into memory.
module imem_loader
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_ra,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [DATA_W-1:0] mem_wd,
  output logic              cpu_stall,
  output logic              load_done,
  output logic [CNT_W-1:0]  word_count,
  output logic              partial_err
);

  state_t              stateQ;
  state_t              stateNext;
  logic                accept;
  logic                loadStart;
  logic                lastWord;
  logic [DATA_W-1:0]   packedWord;
  logic                wordDone;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  phaseAfter;

  byte_packer uPacker (
    .clk           (clk),
    .reset         (reset),
    .accept        (accept),
    .byteIn        (byte_in),
    .clear         (loadStart),
    .wordC         (packedWord),
    .wordCompleteC (wordDone),
    .phase         (phase)
  );

  // Read path is a straight pass-through so fetch sees no extra latency.
  always_comb begin
    mem_ra = cpu_addr;
  end

  // Handshake and derived conditions for this cycle.
  always_comb begin
    accept     = byte_valid && byte_ready;
    loadStart  = (stateQ == IDLE) && start;
    lastWord   = wordDone && (word_count == CNT_W'(DEPTH - 1));
    phaseAfter = phase + PHASE_W'(accept);
  end

  // Next-state logic.
  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (start) stateNext = LOAD;
      LOAD:    if (lastWord || stop) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= IDLE;
    else       stateQ <= stateNext;
  end

  // Registered handshake/status outputs, write port and load bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_ready  <= 1'b0;
      cpu_stall   <= 1'b0;
      load_done   <= 1'b0;
      mem_we      <= 1'b0;
      mem_wa      <= '0;
      mem_wd      <= '0;
      word_count  <= '0;
      partial_err <= 1'b0;
    end else begin
      byte_ready <= (stateNext == LOAD);
      cpu_stall  <= (stateNext != IDLE);
      load_done  <= (stateNext == DONE);
      mem_we     <= wordDone;
      if (wordDone) begin
        mem_wa     <= word_count[ADDR_W-1:0];
        mem_wd     <= packedWord;
        word_count <= word_count + CNT_W'(1);
      end
      if (loadStart) begin
        word_count  <= '0;
        partial_err <= 1'b0;
      end
      // A byte arriving with stop is counted before judging leftovers.
      if ((stateQ == LOAD) && stop) begin
        partial_err <= (phaseAfter != '0);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a transaction-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [5:0]  cpu_addr;
  logic [5:0]  mem_ra;
  logic        mem_we;
  logic [5:0]  mem_wa;
  logic [31:0] mem_wd;
  logic        cpu_stall;
  logic        load_done;
  logic [6:0]  word_count;
  logic        partial_err;

  int checks = 0;
  int errors = 0;

  imem_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .cpu_addr    (cpu_addr),
    .mem_ra      (mem_ra),
    .mem_we      (mem_we),
    .mem_wa      (mem_wa),
    .mem_wd      (mem_wd),
    .cpu_stall   (cpu_stall),
    .load_done   (load_done),
    .word_count  (word_count),
    .partial_err (partial_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory as seen by the DUT's write port, and write counter.
  logic [31:0] dutMem [64];
  int          writes = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      dutMem[mem_wa] <= mem_wd;
      writes <= writes + 1;
    end
  end

  // Reference model: a load is a list of accepted bytes; every fourth byte
  // forms a word written to the next address, the write landing one cycle later.
  logic        mLoad = 0, mDone = 0, mWe = 0, mErr = 0;
  logic [5:0]  mWa = 0;
  logic [31:0] mWd = 0, mAcc = 0;
  int          mBytes = 0, mCnt = 0;
  logic [31:0] expMem [64];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mLoad = 0; mDone = 0; mWe = 0; mErr = 0;
      mWa = 0; mWd = 0; mCnt = 0; mBytes = 0;
    end else begin
      if (mWe) expMem[mWa] = mWd;
      mWe = 0;
      if (mDone) begin
        mDone = 0;
      end else if (mLoad) begin
        if (byte_valid) begin
          mAcc = {mAcc[23:0], byte_in};
          mBytes = mBytes + 1;
          if (mBytes == 4) begin
            mWe = 1; mWa = 6'(mCnt); mWd = mAcc;
            mCnt = mCnt + 1; mBytes = 0;
          end
        end
        if (mCnt == 64 || stop) begin
          mLoad = 0; mDone = 1;
          if (mBytes != 0) mErr = 1;
        end
      end else if (start) begin
        mLoad = 1; mCnt = 0; mErr = 0; mBytes = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("mem_ra",      32'(mem_ra),      32'(cpu_addr));
    chk("byte_ready",  32'(byte_ready),  32'(mLoad));
    chk("cpu_stall",   32'(cpu_stall),   32'(mLoad | mDone));
    chk("load_done",   32'(load_done),   32'(mDone));
    chk("mem_we",      32'(mem_we),      32'(mWe));
    chk("mem_wa",      32'(mem_wa),      32'(mWa));
    chk("mem_wd",      mem_wd,           mWd);
    chk("word_count",  32'(word_count),  32'(mCnt));
    chk("partial_err", 32'(partial_err), 32'(mErr));
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cpu_addr = 6'($urandom);
  endtask

  task automatic doStart();
    start = 1; tick(); start = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    byte_valid = 1; byte_in = b; tick(); byte_valid = 0;
  endtask

  task automatic doStop();
    stop = 1; tick(); stop = 0;
  endtask

  logic [7:0]  b [8];
  logic [31:0] w0, w1, p0, prev0, prev1;
  int          w;

  initial begin
    reset = 1; start = 0; stop = 0; byte_in = 0; byte_valid = 0; cpu_addr = 6'd17;
    #1;
    chk("rst mem_ra", 32'(mem_ra), 32'd17);
    chk("rst cpu_stall", 32'(cpu_stall), 32'd0);
    chk("rst byte_ready", 32'(byte_ready), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    tick(); tick();
    reset = 0;
    tick(); tick();

    // Single word
    doStart();
    sendByte(8'h20); sendByte(8'h08); sendByte(8'h00); sendByte(8'h05);
    chk("single we", 32'(mem_we), 32'd1);
    chk("single wa", 32'(mem_wa), 32'd0);
    chk("single wd", mem_wd, 32'h20080005);
    doStop();
    chk("single done", 32'(load_done), 32'd1);
    chk("single count", 32'(word_count), 32'd1);
    chk("single perr", 32'(partial_err), 32'd0);
    tick();
    chk("single stall", 32'(cpu_stall), 32'd0);
    chk("single mem0", dutMem[0], 32'h20080005);

    // Gapped stream
    w = writes;
    doStart();
    for (int i = 0; i < 8; i++) begin
      b[i] = 8'($urandom);
      sendByte(b[i]);
      tick();
    end
    doStop();
    tick();
    w0 = {b[0], b[1], b[2], b[3]};
    w1 = {b[4], b[5], b[6], b[7]};
    chk("gap writes", 32'(writes - w), 32'd2);
    chk("gap mem0", dutMem[0], w0);
    chk("gap mem1", dutMem[1], w1);
    chk("gap count", 32'(word_count), 32'd2);

    // Partial stop
    doStart();
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom);
      sendByte(b[i]);
    end
    p0 = {b[0], b[1], b[2], b[3]};
    doStop();
    chk("partial perr", 32'(partial_err), 32'd1);
    tick();
    chk("partial count", 32'(word_count), 32'd1);
    chk("partial mem0", dutMem[0], p0);
    chk("partial mem1", dutMem[1], w1);

    // Random loads: random gaps, stray start/stop, stop possibly with a byte
    for (int r = 0; r < 8; r++) begin
      stop = $urandom_range(0, 1);
      doStart();
      stop = 0;
      for (int c = 0, n = $urandom_range(2, 40); c < n; c++) begin
        byte_valid = 1'($urandom);
        byte_in    = 8'($urandom);
        start      = 1'($urandom);
        stop       = (c == n - 1);
        tick();
      end
      byte_valid = 0; start = 0; stop = 0;
      tick(); tick();
    end

    // Full load: limit ends the load without stop
    w = writes;
    doStart();
    byte_valid = 1;
    for (int i = 0; i < 256; i++) begin
      byte_in = 8'($urandom);
      tick();
    end
    chk("full done", 32'(load_done), 32'd1);
    chk("full we", 32'(mem_we), 32'd1);
    chk("full wa", 32'(mem_wa), 32'd63);
    chk("full count", 32'(word_count), 32'd64);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full extra ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 0;
    chk("full writes", 32'(writes - w), 32'd64);

    // Reset kills a pending write
    prev0 = dutMem[0];
    doStart();
    for (int i = 0; i < 4; i++) sendByte(8'($urandom));
    chk("kill we before", 32'(mem_we), 32'd1);
    reset = 1;
    #1;
    chk("kill we", 32'(mem_we), 32'd0);
    tick();
    reset = 0;
    tick();
    chk("kill mem0", dutMem[0], prev0);

    // Reset mid-load after second word's third byte
    prev1 = dutMem[1];
    doStart();
    for (int i = 0; i < 7; i++) begin
      b[i] = 8'($urandom);
      sendByte(b[i]);
    end
    tick();
    reset = 1;
    #1;
    chk("midrst stall", 32'(cpu_stall), 32'd0);
    chk("midrst we", 32'(mem_we), 32'd0);
    chk("midrst count", 32'(word_count), 32'd0);
    chk("midrst ready", 32'(byte_ready), 32'd0);
    tick();
    reset = 0;
    tick();
    chk("midrst mem0", dutMem[0], {b[0], b[1], b[2], b[3]});
    chk("midrst mem1", dutMem[1], prev1);

    for (int i = 0; i < 64; i++) chk("final mem", dutMem[i], expMem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
